// File: rtl/fetch_decode_pipe_stage.sv
// IF/ID pipeline stage: valid/ready handshake with a 2-entry skid buffer, flush with
// bubble insertion and a saturating back-pressure counter.
module fetch_decode_pipe_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013),
  parameter int unsigned     CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             f_valid_i,
  output logic             f_ready_o,
  input  logic [XLEN-1:0]  f_instruction_i,
  input  logic [XLEN-1:0]  f_pcsrc_i,
  input  logic [XLEN-1:0]  f_pc_i,
  input  logic             d_ready_i,
  output logic             fd_valid_o,
  output logic [XLEN-1:0]  fd_instruction_o,
  output logic [XLEN-1:0]  fd_pcsrc_o,
  output logic [XLEN-1:0]  fd_pc_o,
  input  logic             flush_i,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned     EntryW = 3 * XLEN;
  localparam logic [CNT_W-1:0] CntMax = '1;

  // Occupancy encoded directly; valid bits are derived from the state.
  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  state_e              state_q, state_d;
  logic [EntryW-1:0]   main_q, main_d;
  logic [EntryW-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic [EntryW-1:0]   in_entry;
  logic                main_valid;
  logic                skid_valid;
  logic                push;
  logic                pop;

  assign in_entry   = {f_instruction_i, f_pcsrc_i, f_pc_i};
  assign main_valid = (state_q != StEmpty);
  assign skid_valid = (state_q == StSkid);

  assign f_ready_o  = ~skid_valid;
  assign fd_valid_o = main_valid;
  assign push       = f_valid_i & f_ready_o;
  assign pop        = fd_valid_o & d_ready_i;

  assign fd_instruction_o = main_valid ? main_q[3*XLEN-1:2*XLEN] : NOP_INSTR;
  assign fd_pcsrc_o       = main_q[2*XLEN-1:XLEN];
  assign fd_pc_o          = main_q[XLEN-1:0];
  assign stall_cnt_o      = stall_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // Payloads are left stale; only the valid state is cleared.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (push) begin
            main_d  = in_entry;
            state_d = StFull;
          end
        end
        StFull: begin
          if (push && pop) begin
            main_d = in_entry;
          end else if (push) begin
            skid_d  = in_entry;
            state_d = StSkid;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StSkid: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = StFull;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (fd_valid_o && !d_ready_i && (stall_q != CntMax)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_fetch_decode_pipe_stage.sv
// Directed self-checking bench for fetch_decode_pipe_stage: a default 32-bit instance
// and a 64-bit instance with a 4-bit stall counter.
module tb_fetch_decode_pipe_stage;

  logic clk;
  logic rst_n;

  // Default instance (XLEN=32, CNT_W=16)
  logic        a_f_valid, a_f_ready, a_d_ready, a_fd_valid, a_flush;
  logic [31:0] a_instr, a_pcsrc, a_pc;
  logic [31:0] a_fd_instr, a_fd_pcsrc, a_fd_pc;
  logic [15:0] a_stall;

  // Wide instance (XLEN=64, CNT_W=4)
  logic        b_f_valid, b_f_ready, b_d_ready, b_fd_valid, b_flush;
  logic [63:0] b_instr, b_pcsrc, b_pc;
  logic [63:0] b_fd_instr, b_fd_pcsrc, b_fd_pc;
  logic [3:0]  b_stall;

  int checks;
  int failures;

  fetch_decode_pipe_stage u_dut_a (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .f_valid_i       (a_f_valid),
    .f_ready_o       (a_f_ready),
    .f_instruction_i (a_instr),
    .f_pcsrc_i       (a_pcsrc),
    .f_pc_i          (a_pc),
    .d_ready_i       (a_d_ready),
    .fd_valid_o      (a_fd_valid),
    .fd_instruction_o(a_fd_instr),
    .fd_pcsrc_o      (a_fd_pcsrc),
    .fd_pc_o         (a_fd_pc),
    .flush_i         (a_flush),
    .stall_cnt_o     (a_stall)
  );

  fetch_decode_pipe_stage #(
    .XLEN (64),
    .CNT_W(4)
  ) u_dut_b (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .f_valid_i       (b_f_valid),
    .f_ready_o       (b_f_ready),
    .f_instruction_i (b_instr),
    .f_pcsrc_i       (b_pcsrc),
    .f_pc_i          (b_pc),
    .d_ready_i       (b_d_ready),
    .fd_valid_o      (b_fd_valid),
    .fd_instruction_o(b_fd_instr),
    .fd_pcsrc_o      (b_fd_pcsrc),
    .fd_pc_o         (b_fd_pc),
    .flush_i         (b_flush),
    .stall_cnt_o     (b_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle and settle just past the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction and PCsrc are derived from the PC so expectations stay readable.
  task automatic drive_a(input logic valid, input logic [31:0] pc);
    a_f_valid = valid;
    a_pc      = pc;
    a_instr   = pc | 32'h1000_0000;
    a_pcsrc   = pc + 32'd4;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b1;
    a_flush   = 1'b0;
    a_d_ready = 1'b0;
    drive_a(1'b0, 32'h0);
    b_f_valid = 1'b0;
    b_d_ready = 1'b0;
    b_flush   = 1'b0;
    b_instr   = '0;
    b_pcsrc   = '0;
    b_pc      = '0;

    #2 rst_n = 1'b0;
    tick();
    tick();
    check("rst_valid", 64'(a_fd_valid), 64'h0);
    check("rst_instr", 64'(a_fd_instr), 64'h13);
    check("rst_pc", 64'(a_fd_pc), 64'h0);
    check("rst_pcsrc", 64'(a_fd_pcsrc), 64'h0);
    check("rst_ready", 64'(a_f_ready), 64'h1);
    check("rst_stall", 64'(a_stall), 64'h0);
    check("rst_b_instr", b_fd_instr, 64'h13);
    rst_n = 1'b1;
    tick();

    // Streaming at full rate.
    a_d_ready = 1'b1;
    drive_a(1'b1, 32'h100);
    tick();
    check("s0_pc", 64'(a_fd_pc), 64'h100);
    check("s0_instr", 64'(a_fd_instr), 64'h1000_0100);
    check("s0_pcsrc", 64'(a_fd_pcsrc), 64'h104);
    check("s0_valid", 64'(a_fd_valid), 64'h1);
    check("s0_ready", 64'(a_f_ready), 64'h1);
    drive_a(1'b1, 32'h104);
    tick();
    check("s1_pc", 64'(a_fd_pc), 64'h104);
    check("s1_valid", 64'(a_fd_valid), 64'h1);
    check("s1_ready", 64'(a_f_ready), 64'h1);
    drive_a(1'b1, 32'h108);
    tick();
    check("s2_pc", 64'(a_fd_pc), 64'h108);
    check("s2_valid", 64'(a_fd_valid), 64'h1);
    check("s2_ready", 64'(a_f_ready), 64'h1);
    drive_a(1'b0, 32'h0);
    tick();
    check("s3_valid", 64'(a_fd_valid), 64'h0);
    check("s3_instr", 64'(a_fd_instr), 64'h13);
    check("s_stall", 64'(a_stall), 64'h0);

    // Back-pressure into the skid entry.
    a_d_ready = 1'b0;
    drive_a(1'b1, 32'h200);
    tick();
    check("b0_pc", 64'(a_fd_pc), 64'h200);
    check("b0_ready", 64'(a_f_ready), 64'h1);
    check("b0_stall", 64'(a_stall), 64'h0);
    drive_a(1'b1, 32'h204);
    tick();
    check("b1_ready", 64'(a_f_ready), 64'h0);
    check("b1_pc", 64'(a_fd_pc), 64'h200);
    check("b1_stall", 64'(a_stall), 64'h1);
    drive_a(1'b1, 32'h208);
    tick();
    check("b2_ready", 64'(a_f_ready), 64'h0);
    check("b2_pc", 64'(a_fd_pc), 64'h200);
    check("b2_stall", 64'(a_stall), 64'h2);
    drive_a(1'b0, 32'h0);
    a_d_ready = 1'b1;
    tick();
    check("b3_pc", 64'(a_fd_pc), 64'h204);
    check("b3_instr", 64'(a_fd_instr), 64'h1000_0204);
    check("b3_valid", 64'(a_fd_valid), 64'h1);
    check("b3_ready", 64'(a_f_ready), 64'h1);
    tick();
    check("b4_valid", 64'(a_fd_valid), 64'h0);
    check("b4_stall", 64'(a_stall), 64'h2);

    // Flush while in SKID with a simultaneous push.
    a_d_ready = 1'b0;
    drive_a(1'b1, 32'h300);
    tick();
    drive_a(1'b1, 32'h304);
    tick();
    check("f0_ready", 64'(a_f_ready), 64'h0);
    check("f0_stall", 64'(a_stall), 64'h3);
    drive_a(1'b1, 32'h308);
    a_flush = 1'b1;
    tick();
    check("f1_valid", 64'(a_fd_valid), 64'h0);
    check("f1_instr", 64'(a_fd_instr), 64'h13);
    check("f1_ready", 64'(a_f_ready), 64'h1);
    check("f1_stall", 64'(a_stall), 64'h4);
    a_flush = 1'b0;
    drive_a(1'b0, 32'h0);
    a_d_ready = 1'b1;
    tick();
    check("f2_valid", 64'(a_fd_valid), 64'h0);
    tick();
    check("f3_valid", 64'(a_fd_valid), 64'h0);
    check("f3_stall", 64'(a_stall), 64'h4);

    // Asynchronous reset while FULL.
    drive_a(1'b1, 32'h400);
    tick();
    drive_a(1'b0, 32'h0);
    a_d_ready = 1'b0;
    tick();
    check("r0_valid", 64'(a_fd_valid), 64'h1);
    check("r0_stall", 64'(a_stall), 64'h5);
    #2 rst_n = 1'b0;
    #1;
    check("r1_valid", 64'(a_fd_valid), 64'h0);
    check("r1_instr", 64'(a_fd_instr), 64'h13);
    check("r1_stall", 64'(a_stall), 64'h0);
    check("r1_ready", 64'(a_f_ready), 64'h1);
    check("r1_pc", 64'(a_fd_pc), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Wide datapath and counter saturation.
    b_f_valid = 1'b1;
    b_pc      = 64'hFFFF_FFFF_0000_0000;
    b_pcsrc   = 64'h1234_5678_9ABC_DEF0;
    b_instr   = 64'hDEAD_BEEF_0000_0033;
    tick();
    check("w_pc", b_fd_pc, 64'hFFFF_FFFF_0000_0000);
    check("w_pcsrc", b_fd_pcsrc, 64'h1234_5678_9ABC_DEF0);
    check("w_instr", b_fd_instr, 64'hDEAD_BEEF_0000_0033);
    check("w_valid", 64'(b_fd_valid), 64'h1);
    b_f_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) check("sat_14", 64'(b_stall), 64'd14);
      if (i == 15) check("sat_15", 64'(b_stall), 64'd15);
    end
    check("sat_20", 64'(b_stall), 64'd15);
    check("sat_valid", 64'(b_fd_valid), 64'h1);
    b_d_ready = 1'b1;
    tick();
    check("w_drain", 64'(b_fd_valid), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
